// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M/RV64M multiply/divide sequencer for EX.
// Magnitude datapath, BPC bits per cycle, sign fixed in a final cycle.
module muldiv_seq #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int N  = XLEN / BPC;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [XLEN-1:0] MIN_NEG =
        {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE, CALC, FIX, DONE
    } state_t;

    state_t state, state_n;

    logic [2:0]        op_q;
    logic              neg_a, neg_b;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] acc, acc_n;
    logic [XLEN-1:0]   rem, rem_n;

    logic              accept;
    logic              sgn_a, sgn_b;
    logic              na, nb;
    logic [XLEN-1:0]   mag_a_in, mag_b_in;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   spec_res;

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   q_fix, r_fix, fix_res;

    logic [XLEN:0]     sum;
    logic [XLEN:0]     trial;

    // Acceptance decode: operand signs, magnitudes, corner cases
    always_comb begin
        accept = (state == IDLE) & start & ~flush;
        sgn_a  = 1'b0;
        sgn_b  = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sgn_a = 1'b1;
                sgn_b = 1'b1;
            end
            3'b010:  sgn_a = 1'b1;
            default: ;
        endcase
        na       = sgn_a & rs1[XLEN-1];
        nb       = sgn_b & rs2[XLEN-1];
        mag_a_in = na ? -rs1 : rs1;
        mag_b_in = nb ? -rs2 : rs2;
        div_zero = funct3[2] & (rs2 == '0);
        div_ovf  = funct3[2] & ~funct3[0]
                 & (rs1 == MIN_NEG) & (rs2 == '1);
        special  = div_zero | div_ovf;
        if (div_zero & ~funct3[1])
            spec_res = '1;
        else if (div_zero)
            spec_res = rs1;
        else if (~funct3[1])
            spec_res = MIN_NEG;
        else
            spec_res = '0;
    end

    // One CALC step: BPC shift-add or restoring-divide bits
    always_comb begin
        acc_n = acc;
        rem_n = rem;
        sum   = '0;
        trial = '0;
        if (op_q[2]) begin
            for (int i = 0; i < BPC; i++) begin
                trial = {rem_n, acc_n[XLEN-1]};
                acc_n = {acc_n[2*XLEN-1:XLEN],
                         acc_n[XLEN-2:0], 1'b0};
                if (trial >= {1'b0, mag_b}) begin
                    trial    = trial - {1'b0, mag_b};
                    acc_n[0] = 1'b1;
                end
                rem_n = trial[XLEN-1:0];
            end
        end else begin
            for (int i = 0; i < BPC; i++) begin
                sum = {1'b0, acc_n[2*XLEN-1:XLEN]}
                    + (acc_n[0] ? {1'b0, mag_b}
                                : {(XLEN+1){1'b0}});
                acc_n = {sum, acc_n[XLEN-1:1]};
            end
        end
    end

    // FIX-stage sign correction and result select
    always_comb begin
        prod  = (neg_a ^ neg_b) ? -acc : acc;
        q_fix = (neg_a ^ neg_b) ? -acc[XLEN-1:0]
                                : acc[XLEN-1:0];
        r_fix = neg_a ? -rem : rem;
        if (~op_q[2])
            fix_res = (op_q[1:0] == 2'b00)
                    ? prod[XLEN-1:0]
                    : prod[2*XLEN-1:XLEN];
        else if (~op_q[1])
            fix_res = q_fix;
        else
            fix_res = r_fix;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (accept)
                          state_n = special ? DONE : CALC;
                CALC: if (cnt == LAST)
                          state_n = FIX;
                FIX:  state_n = DONE;
                DONE: state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        busy  = (state != IDLE);
        done  = (state == DONE);
        stall = (start & (state == IDLE) & ~flush)
              | (busy & ~done);
    end

    // Datapath registers and result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            cnt    <= '0;
            mag_b  <= '0;
            acc    <= '0;
            rem    <= '0;
            result <= '0;
        end else if (accept) begin
            op_q  <= funct3;
            neg_a <= na;
            neg_b <= nb;
            cnt   <= '0;
            mag_b <= mag_b_in;
            acc   <= {{XLEN{1'b0}}, mag_a_in};
            rem   <= '0;
            if (special)
                result <= spec_res;
        end else if (state == CALC) begin
            acc <= acc_n;
            rem <= rem_n;
            cnt <= cnt + CW'(1);
        end else if (state == FIX && !flush) begin
            result <= fix_res;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed table plus random sweep against an
// arithmetic reference model, on a 32/2 and a 64/4 instance.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        busy, stall, done;
    logic [31:0] result;

    logic        start64 = 1'b0;
    logic        flush64 = 1'b0;
    logic [2:0]  f64 = '0;
    logic [63:0] a64 = '0;
    logic [63:0] b64 = '0;
    logic        busy64, stall64, done64;
    logic [63:0] res64;

    int compared = 0;
    int mismatched = 0;

    muldiv_seq #(.XLEN(32), .BPC(2)) u32 (
        .clk(clk), .rst(rst), .start(start),
        .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .flush(flush), .busy(busy), .stall(stall),
        .done(done), .result(result)
    );

    muldiv_seq #(.XLEN(64), .BPC(4)) u64 (
        .clk(clk), .rst(rst), .start(start64),
        .funct3(f64), .rs1(a64), .rs2(b64),
        .flush(flush64), .busy(busy64), .stall(stall64),
        .done(done64), .result(res64)
    );

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    // Reference: signed/unsigned arithmetic at width w
    function automatic logic [63:0] ref_model(
        input logic [2:0] f, input logic [63:0] a,
        input logic [63:0] b, input int w);
        logic signed [129:0] sa, sb, ua, ub, r;
        logic [63:0] mask;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                         : 64'h0000_0000_FFFF_FFFF;
        ua = 130'(a & mask);
        ub = 130'(b & mask);
        if (w == 64) begin
            sa = 130'($signed(a));
            sb = 130'($signed(b));
        end else begin
            sa = 130'($signed(a[31:0]));
            sb = 130'($signed(b[31:0]));
        end
        case (f)
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> w;
            3'd2: r = (sa * ub) >>> w;
            3'd3: r = (ua * ub) >>> w;
            3'd4: r = (ub == 0) ? -130'sd1 : sa / sb;
            3'd5: r = (ub == 0) ? -130'sd1 : ua / ub;
            3'd6: r = (ub == 0) ? sa : sa % sb;
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return r[63:0] & mask;
    endfunction

    function automatic int ref_lat(
        input logic [2:0] f, input logic [63:0] a,
        input logic [63:0] b, input int w);
        logic [63:0] mask, mn;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                         : 64'h0000_0000_FFFF_FFFF;
        mn = (w == 64) ? 64'h8000_0000_0000_0000
                       : 64'h0000_0000_8000_0000;
        if (f[2] && (b & mask) == 0)
            return 1;
        if ((f == 3'd4 || f == 3'd6) &&
            (a & mask) == mn && (b & mask) == mask)
            return 1;
        return 18;
    endfunction

    task automatic run_op(input logic [2:0] f,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          output logic [31:0] res,
                          output int lat,
                          output bit stall_ok);
        stall_ok = 1'b1;
        lat = 0;
        @(negedge clk);
        funct3 = f;
        rs1 = a;
        rs2 = b;
        start = 1'b1;
        #1;
        if (!stall) stall_ok = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (!stall) stall_ok = 1'b0;
        end
        if (done && stall) stall_ok = 1'b0;
        res = result;
    endtask

    task automatic run_pair(input logic [2:0] fa,
                            input logic [31:0] a,
                            input logic [31:0] b,
                            input logic [2:0] fb,
                            input logic [63:0] c64,
                            input logic [63:0] d64);
        logic [31:0] r32;
        logic [63:0] r64;
        int l32, l64;
        l32 = 0;
        l64 = 0;
        r32 = '0;
        r64 = '0;
        @(negedge clk);
        funct3 = fa; rs1 = a; rs2 = b;
        f64 = fb; a64 = c64; b64 = d64;
        start = 1'b1;
        start64 = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start64 = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done && l32 == 0) begin
                l32 = c;
                r32 = result;
            end
            if (done64 && l64 == 0) begin
                l64 = c;
                r64 = res64;
            end
            if (l32 != 0 && l64 != 0) break;
        end
        check("rnd32_res", 64'(r32),
              ref_model(fa, 64'(a), 64'(b), 32));
        check("rnd32_lat", 64'(l32),
              64'(ref_lat(fa, 64'(a), 64'(b), 32)));
        check("rnd64_res", r64,
              ref_model(fb, c64, d64, 64));
        check("rnd64_lat", 64'(l64),
              64'(ref_lat(fb, c64, d64, 64)));
    endtask

    function automatic logic [31:0] pick32(input int k);
        case (k)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [63:0] pick64(input int k);
        case (k)
            0: return 64'h0;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [31:0] res, prev;
        int lat;
        bit sok;

        vecs[0]  = '{"mul",     3'd0, 32'd7,
                     32'hFFFF_FFFD, 32'hFFFF_FFEB, 18};
        vecs[1]  = '{"mulh",    3'd1, 32'h8000_0000,
                     32'h8000_0000, 32'h4000_0000, 18};
        vecs[2]  = '{"mulhsu",  3'd2, 32'hFFFF_FFFF,
                     32'hFFFF_FFFF, 32'hFFFF_FFFF, 18};
        vecs[3]  = '{"mulhu",   3'd3, 32'hFFFF_FFFF,
                     32'hFFFF_FFFF, 32'hFFFF_FFFE, 18};
        vecs[4]  = '{"div",     3'd4, 32'hFFFF_FFF9,
                     32'd2, 32'hFFFF_FFFD, 18};
        vecs[5]  = '{"rem",     3'd6, 32'hFFFF_FFF9,
                     32'd2, 32'hFFFF_FFFF, 18};
        vecs[6]  = '{"divu",    3'd5, 32'd100,
                     32'd7, 32'd14, 18};
        vecs[7]  = '{"remu",    3'd7, 32'd100,
                     32'd7, 32'd2, 18};
        vecs[8]  = '{"divu_z",  3'd5, 32'd5,
                     32'd0, 32'hFFFF_FFFF, 1};
        vecs[9]  = '{"rem_z",   3'd6, 32'd5,
                     32'd0, 32'd5, 1};
        vecs[10] = '{"div_ovf", 3'd4, 32'h8000_0000,
                     32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{"rem_ovf", 3'd6, 32'h8000_0000,
                     32'hFFFF_FFFF, 32'd0, 1};
        vecs[12] = '{"mulh_neg", 3'd1, 32'hFFFF_FFFE,
                     32'd3, 32'hFFFF_FFFF, 18};

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b,
                   res, lat, sok);
            check({vecs[i].name, "_res"},
                  64'(res), 64'(vecs[i].exp));
            check({vecs[i].name, "_lat"},
                  64'(lat), 64'(vecs[i].lat));
            check({vecs[i].name, "_stall"},
                  64'(sok), 64'd1);
        end

        // flush mid-CALC: abort, result held
        prev = result;
        @(negedge clk);
        funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_result", 64'(result), 64'(prev));
        run_op(3'd5, 32'd9, 32'd3, res, lat, sok);
        check("post_flush_res", 64'(res), 64'd3);
        check("post_flush_lat", 64'(lat), 64'd18);

        // start held high with new operands while busy
        @(negedge clk);
        funct3 = 3'd0; rs1 = 32'd6; rs2 = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd3;
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        check("busy_start_res", 64'(result), 64'd42);
        check("busy_start_lat", 64'(lat), 64'd18);

        // async reset mid-CALC
        @(negedge clk);
        @(negedge clk);
        funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd10;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_stall", 64'(stall), 64'd0);
        check("arst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd7, 32'd1000, 32'd7, res, lat, sok);
        check("post_rst_res", 64'(res), 64'd6);
        check("post_rst_lat", 64'(lat), 64'd18);

        // random sweep on both widths
        for (int n = 0; n < 1500; n++) begin
            logic [2:0] fa, fb;
            logic [31:0] a, b;
            logic [63:0] c, d;
            fa = 3'($urandom_range(0, 7));
            fb = 3'($urandom_range(0, 7));
            a = pick32($urandom_range(0, 12));
            b = pick32($urandom_range(0, 12));
            c = pick64($urandom_range(0, 12));
            d = pick64($urandom_range(0, 12));
            run_pair(fa, a, b, fb, c, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
